branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised branch target buffer with per-entry N-bit saturating direction counters. It replaces the single fixed 2-bit FSM with a direct-mapped, tagged table. The IF stage reads a next-PC prediction in the same cycle. The EX stage writes back resolved outcomes one cycle later, and a flush-driven clear sequencer invalidates the table.

## Interface
- XLEN, 32: PC and target width.
- IDX_BITS, 5: table index width; DEPTH = 2^IDX_BITS entries.
- TAG_BITS, 8: stored tag width.
- CTR_BITS, 2: direction counter width, ≥2.
- clk  in  1  sole clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pred_pc  in  XLEN  fetch PC to look up.
- pred_hit  out  1  valid entry whose tag matches pred_pc.
- pred_taken  out  1  pred_hit AND counter MSB = 1.
- pred_target  out  XLEN  stored target on hit, else 0.
- upd_valid  in  1  a resolved branch is presented this cycle.
- upd_pc  in  XLEN  PC of the resolved branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  XLEN  actual target; used only when taken.
- flush  in  1  one-cycle request to invalidate the whole table.
- busy  out  1  high while the clear sweep runs.

## Operation
- Index is pc[IDX_BITS+1:2]. Tag is pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2]. pc[1:0] is ignored.
- Each entry holds valid, tag[TAG_BITS], target[XLEN] and ctr[CTR_BITS].
- Prediction is a combinational read of the registered table. No write-to-read bypass.
- Update rules, applied only when upd_valid=1 and the FSM is IDLE:
  - On a hit with taken: ctr saturating-increments (stops at 2^CTR_BITS−1) and target ← upd_target.
  - On a hit with not taken: ctr saturating-decrements (stops at 0) and target is unchanged.
  - On a miss with taken: allocate or overwrite. valid ← 1, tag written, target ← upd_target, ctr ← 2^(CTR_BITS−1) (weakly taken).
  - On a miss with not taken: no write.
- FSM states:
  - IDLE: when flush=1, go to CLEAR with clr_idx ← 0.
  - CLEAR: each cycle invalidate entry clr_idx and increment clr_idx.
    - After clearing index DEPTH−1, return to IDLE.
    - flush=1 during CLEAR restarts the sweep with clr_idx ← 0.
- While in CLEAR: busy=1, pred_hit=0, pred_taken=0, pred_target=0, and all updates are dropped.
- flush and upd_valid in the same IDLE cycle: flush wins and the update is dropped.
- Reset values:
  - All valid bits = 0, all counters = 0, FSM = IDLE, clr_idx = 0.
  - Tag and target arrays may also reset to 0.
  - Outputs: pred_hit=0, pred_taken=0, pred_target=0, busy=0.
- Reset mid-sweep aborts immediately to IDLE with the table invalid.

## Timing
- Prediction latency is 0 cycles: outputs are a combinational function of pred_pc and the table state.
- An update presented in cycle N becomes visible to prediction in cycle N+1. A read of the same index in cycle N returns the old contents.
- A flush asserted in cycle N puts busy=1 from cycle N+1 for exactly DEPTH cycles. The first cycle in IDLE after the sweep accepts updates.
- Aliasing: two PCs with equal index but different tag evict each other. This is not an error.

## Structure
- Package bp_pkg holds:
  - the state enum {BP_IDLE, BP_CLEAR};
  - the entry struct typedef, parametrised through the module;
  - localparam helpers for index and tag slicing.
- Sub-module bp_sat_ctr (parameter W):
  - Pure next-value function with inputs ctr and inc and output ctr_next, saturating at both ends.
  - Instantiated once on the update path.
- Arrays are flops, not SRAM macros, because the async read and async reset are required.

## Test plan
- After reset, pred_pc=0x100 → pred_hit=0, pred_taken=0, pred_target=0, busy=0.
- Update pc=0x100, taken, target=0x200 → next cycle pred_pc=0x100 gives hit=1, taken=1 (ctr=2), target=0x200.
- Four further taken updates to 0x100, then one not-taken → ctr saturates at 3, then reads 2 with pred_taken=1. A second not-taken → ctr=1 and pred_taken=0.
- Aliasing:
  - Update pc=0x100 taken→0x200, then pc=0x100+(DEPTH·4) taken→0x300.
  - Lookup 0x100 gives pred_hit=0; lookup of the second PC gives hit with target 0x300.
- Pulse flush with the table populated:
  - busy is high for exactly DEPTH=32 cycles and every lookup misses during that time.
  - Updates issued during the sweep are not visible afterward.
  - Flush again at sweep cycle 10 → total busy = 10+32 cycles.
- Boundary events:
  - flush and upd_valid in the same cycle → update discarded.
  - Assert rst_n=0 mid-sweep → busy=0 immediately and all lookups miss.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and PC-slicing helpers for the tagged branch target buffer.
package bp_pkg;

    // Table controller: normal operation or invalidation sweep.
    typedef enum logic {
        BP_IDLE  = 1'b0,
        BP_CLEAR = 1'b1
    } bp_state_e;

    // pc[1:0] never takes part in indexing; the index starts at bit 2.
    localparam int unsigned BP_IDX_LSB = 2;

    function automatic int unsigned bp_idx_msb(input int unsigned idx_bits);
        return BP_IDX_LSB + idx_bits - 1;
    endfunction

    // The tag sits directly above the index bits.
    function automatic int unsigned bp_tag_lsb(input int unsigned idx_bits);
        return BP_IDX_LSB + idx_bits;
    endfunction

    function automatic int unsigned bp_tag_msb(input int unsigned idx_bits,
                                               input int unsigned tag_bits);
        return BP_IDX_LSB + idx_bits + tag_bits - 1;
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Next-value function of a W-bit up/down counter that saturates at both ends.
module bp_sat_ctr #(
    parameter int unsigned W = 2
) (
    input  logic [W-1:0] ctr,
    input  logic         inc,
    output logic [W-1:0] ctr_next
);

    // Step toward the requested direction unless already pinned at that end.
    always_comb begin
        ctr_next = ctr;
        if (inc && (ctr != '1)) begin
            ctr_next = ctr + 1'b1;
        end else if (!inc && (ctr != '0)) begin
            ctr_next = ctr - 1'b1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped, tagged branch target buffer with per-entry saturating
// direction counters. Lookup is a same-cycle read of the flop table; resolved
// branches write back on the clock edge; a flush runs a one-entry-per-cycle
// invalidation sweep during which lookups miss and updates are dropped.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned IDX_BITS = 5,
    parameter int unsigned TAG_BITS = 8,
    parameter int unsigned CTR_BITS = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pred_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            flush,
    output logic            busy
);

    localparam int unsigned DEPTH   = 1 << IDX_BITS;
    localparam int unsigned IDX_MSB = bp_idx_msb(IDX_BITS);
    localparam int unsigned TAG_LSB = bp_tag_lsb(IDX_BITS);
    localparam int unsigned TAG_MSB = bp_tag_msb(IDX_BITS, TAG_BITS);

    // A fresh allocation starts weakly taken: MSB set, rest clear.
    localparam logic [CTR_BITS-1:0] CTR_WEAK = {1'b1, {(CTR_BITS-1){1'b0}}};
    localparam logic [IDX_BITS-1:0] CLR_LAST = '1;

    typedef struct packed {
        logic                valid;
        logic [TAG_BITS-1:0] tag;
        logic [XLEN-1:0]     target;
        logic [CTR_BITS-1:0] ctr;
    } entry_t;

    entry_t              tbl_q [DEPTH];
    bp_state_e           state_q, state_d;
    logic [IDX_BITS-1:0] clr_idx_q, clr_idx_d;

    // ---------------- lookup ----------------
    logic [IDX_BITS-1:0] p_idx;
    logic [TAG_BITS-1:0] p_tag;
    entry_t              p_ent;

    assign p_idx = pred_pc[IDX_MSB:BP_IDX_LSB];
    assign p_tag = pred_pc[TAG_MSB:TAG_LSB];
    assign p_ent = tbl_q[p_idx];
    assign busy  = (state_q == BP_CLEAR);

    // Hit only on a valid, tag-matching entry and never while sweeping.
    always_comb begin
        pred_hit    = 1'b0;
        pred_taken  = 1'b0;
        pred_target = '0;
        if (!busy && p_ent.valid && (p_ent.tag == p_tag)) begin
            pred_hit    = 1'b1;
            pred_taken  = p_ent.ctr[CTR_BITS-1];
            pred_target = p_ent.target;
        end
    end

    // ---------------- update ----------------
    logic [IDX_BITS-1:0] u_idx;
    logic [TAG_BITS-1:0] u_tag;
    entry_t              u_ent;
    entry_t              u_new;
    logic                u_hit;
    logic                u_we;
    logic [CTR_BITS-1:0] u_ctr_next;

    assign u_idx = upd_pc[IDX_MSB:BP_IDX_LSB];
    assign u_tag = upd_pc[TAG_MSB:TAG_LSB];
    assign u_ent = tbl_q[u_idx];
    assign u_hit = u_ent.valid && (u_ent.tag == u_tag);

    bp_sat_ctr #(.W(CTR_BITS)) u_sat_ctr (
        .ctr      (u_ent.ctr),
        .inc      (upd_taken),
        .ctr_next (u_ctr_next)
    );

    // Build the entry to write back; a flush in the same cycle discards it.
    always_comb begin
        u_we  = 1'b0;
        u_new = u_ent;
        if ((state_q == BP_IDLE) && upd_valid && !flush) begin
            if (u_hit) begin
                u_we      = 1'b1;
                u_new.ctr = u_ctr_next;
                if (upd_taken) begin
                    u_new.target = upd_target;
                end
            end else if (upd_taken) begin
                u_we         = 1'b1;
                u_new.valid  = 1'b1;
                u_new.tag    = u_tag;
                u_new.target = upd_target;
                u_new.ctr    = CTR_WEAK;
            end
        end
    end

    // ---------------- sweep controller ----------------
    // Next state: start or restart the sweep on flush, leave after the last index.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        unique case (state_q)
            BP_IDLE: begin
                if (flush) begin
                    state_d   = BP_CLEAR;
                    clr_idx_d = '0;
                end
            end
            BP_CLEAR: begin
                if (flush) begin
                    clr_idx_d = '0;
                end else if (clr_idx_q == CLR_LAST) begin
                    state_d   = BP_IDLE;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            default: begin
                state_d   = BP_IDLE;
                clr_idx_d = '0;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BP_IDLE;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Table storage: sweep invalidates one entry per cycle, otherwise write back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= '0;
            end
        end else if (state_q == BP_CLEAR) begin
            tbl_q[clr_idx_q].valid <= 1'b0;
        end else if (u_we) begin
            tbl_q[u_idx] <= u_new;
        end
    end

    // PC bits outside index and tag do not affect the table.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[BP_IDX_LSB-1:0], pred_pc[XLEN-1:TAG_MSB+1],
                              upd_pc[BP_IDX_LSB-1:0],  upd_pc[XLEN-1:TAG_MSB+1]};

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed table, hand sequences for the sweep
// corner cases, then random traffic against a behavioural model.
module tb_branch_predictor;

    localparam int XLEN     = 32;
    localparam int IDX_BITS = 5;
    localparam int TAG_BITS = 8;
    localparam int CTR_BITS = 2;
    localparam int DEPTH    = 1 << IDX_BITS;
    localparam int CMAX     = (1 << CTR_BITS) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [XLEN-1:0] pred_pc;
    logic            pred_hit, pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic            flush;
    logic            busy;

    always #5 clk = ~clk;

    branch_predictor #(
        .XLEN(XLEN), .IDX_BITS(IDX_BITS), .TAG_BITS(TAG_BITS), .CTR_BITS(CTR_BITS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pred_pc     (pred_pc),
        .pred_hit    (pred_hit),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .flush       (flush),
        .busy        (busy)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- behavioural model ----------------
    bit              m_valid [DEPTH];
    int              m_tag   [DEPTH];
    logic [XLEN-1:0] m_tgt   [DEPTH];
    int              m_ctr   [DEPTH];
    int              m_busy_left;   // remaining sweep cycles, 0 = idle

    function automatic int idx_of(input logic [XLEN-1:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    function automatic int tag_of(input logic [XLEN-1:0] pc);
        return int'((pc >> (2 + IDX_BITS)) % (1 << TAG_BITS));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = '0; m_ctr[i] = 0;
        end
        m_busy_left = 0;
    endtask

    task automatic model_step();
        int i;
        if (!rst_n) begin
            model_reset();
        end else if (m_busy_left > 0) begin
            m_valid[DEPTH - m_busy_left] = 0;
            if (flush) m_busy_left = DEPTH;
            else       m_busy_left = m_busy_left - 1;
        end else if (flush) begin
            m_busy_left = DEPTH;
        end else if (upd_valid) begin
            i = idx_of(upd_pc);
            if (m_valid[i] && m_tag[i] == tag_of(upd_pc)) begin
                if (upd_taken) begin
                    m_ctr[i] = (m_ctr[i] < CMAX) ? m_ctr[i] + 1 : CMAX;
                    m_tgt[i] = upd_target;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (upd_taken) begin
                m_valid[i] = 1;
                m_tag[i]   = tag_of(upd_pc);
                m_tgt[i]   = upd_target;
                m_ctr[i]   = (CMAX + 1) / 2;
            end
        end
    endtask

    task automatic model_pred(input logic [XLEN-1:0] pc, output logic h, output logic t,
                              output logic [XLEN-1:0] tg);
        int i;
        i = idx_of(pc);
        h = 0; t = 0; tg = '0;
        if (m_busy_left == 0 && m_valid[i] && m_tag[i] == tag_of(pc)) begin
            h  = 1;
            t  = (m_ctr[i] >= (CMAX + 1) / 2);
            tg = m_tgt[i];
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic uv, input logic [XLEN-1:0] upc, input logic ut,
                         input logic [XLEN-1:0] utg, input logic fl, input logic [XLEN-1:0] ppc);
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utg;
        flush = fl; pred_pc = ppc;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        logic            uv;
        logic [XLEN-1:0] upc;
        logic            ut;
        logic [XLEN-1:0] utg;
        logic            fl;
        logic [XLEN-1:0] ppc;
        logic            eh;
        logic            et;
        logic [XLEN-1:0] etg;
        logic            eb;
    } vec_t;

    vec_t vecs [16];

    initial begin
        logic            mh, mt;
        logic [XLEN-1:0] mtg;
        logic [XLEN-1:0] rpc;
        int              n;

        // expectations describe outputs before this row's update takes effect
        vecs[0]  = '{0, 32'h0,    0, 32'h0,   0, 32'h100,  0, 0, 32'h0,   0}; // reset state
        vecs[1]  = '{1, 32'h100,  1, 32'h200, 0, 32'h100,  0, 0, 32'h0,   0}; // no bypass
        vecs[2]  = '{1, 32'h100,  1, 32'h200, 0, 32'h100,  1, 1, 32'h200, 0}; // ctr 2
        vecs[3]  = '{1, 32'h100,  1, 32'h200, 0, 32'h100,  1, 1, 32'h200, 0};
        vecs[4]  = '{1, 32'h100,  1, 32'h200, 0, 32'h100,  1, 1, 32'h200, 0};
        vecs[5]  = '{1, 32'h100,  1, 32'h200, 0, 32'h100,  1, 1, 32'h200, 0};
        vecs[6]  = '{1, 32'h100,  0, 32'h0,   0, 32'h100,  1, 1, 32'h200, 0}; // sat 3 -> 2
        vecs[7]  = '{1, 32'h100,  0, 32'h0,   0, 32'h100,  1, 1, 32'h200, 0}; // 2 -> 1
        vecs[8]  = '{1, 32'h180,  1, 32'h300, 0, 32'h100,  1, 0, 32'h200, 0}; // ctr 1, alias
        vecs[9]  = '{0, 32'h0,    0, 32'h0,   0, 32'h100,  0, 0, 32'h0,   0}; // evicted
        vecs[10] = '{0, 32'h0,    0, 32'h0,   0, 32'h180,  1, 1, 32'h300, 0};
        vecs[11] = '{1, 32'h180,  0, 32'h999, 0, 32'h180,  1, 1, 32'h300, 0}; // NT keeps target
        vecs[12] = '{1, 32'h1000, 0, 32'h777, 0, 32'h180,  1, 0, 32'h300, 0}; // miss NT no write
        vecs[13] = '{0, 32'h0,    0, 32'h0,   0, 32'h183,  1, 0, 32'h300, 0}; // pc[1:0] ignored
        vecs[14] = '{0, 32'h0,    0, 32'h0,   0, 32'h1000, 0, 0, 32'h0,   0};
        vecs[15] = '{1, 32'h400,  1, 32'h500, 1, 32'h180,  1, 0, 32'h300, 0}; // flush wins

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // ---- directed table ----
        for (int r = 0; r < 16; r++) begin
            drive(vecs[r].uv, vecs[r].upc, vecs[r].ut, vecs[r].utg, vecs[r].fl, vecs[r].ppc);
            #1;
            chk($sformatf("row%0d hit", r),    {31'b0, pred_hit},   {31'b0, vecs[r].eh});
            chk($sformatf("row%0d taken", r),  {31'b0, pred_taken}, {31'b0, vecs[r].et});
            chk($sformatf("row%0d target", r), pred_target,         vecs[r].etg);
            chk($sformatf("row%0d busy", r),   {31'b0, busy},       {31'b0, vecs[r].eb});
            tick();
        end

        // ---- sweep from row 15: busy exactly DEPTH cycles, all lookups miss ----
        for (int c = 0; c < DEPTH; c++) begin
            if (c == 5) drive(1, 32'h604, 1, 32'h700, 0, 32'h180);
            else        drive(0, 0, 0, 0, 0, 32'h180);
            #1;
            chk($sformatf("sweep%0d busy", c), {31'b0, busy},     32'd1);
            chk($sformatf("sweep%0d hit", c),  {31'b0, pred_hit}, 32'd0);
            chk($sformatf("sweep%0d tgt", c),  pred_target,       32'd0);
            tick();
        end
        // first idle cycle: sweep-time update absent, new update accepted
        drive(1, 32'h604, 1, 32'h700, 0, 32'h604);
        #1;
        chk("post sweep busy", {31'b0, busy}, 32'd0);
        chk("dropped upd hit", {31'b0, pred_hit}, 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 32'h604);
        #1;
        chk("first idle upd hit", {31'b0, pred_hit}, 32'd1);
        chk("first idle upd tgt", pred_target, 32'h700);
        tick();
        drive(0, 0, 0, 0, 0, 32'h400);
        #1;
        chk("flush+upd dropped", {31'b0, pred_hit}, 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 32'h180);
        #1;
        chk("cleared entry", {31'b0, pred_hit}, 32'd0);
        tick();

        // ---- restart: flush again on the 10th busy cycle ----
        drive(0, 0, 0, 0, 1, 32'h604);
        tick();
        n = 0;
        for (int c = 0; c < 200; c++) begin
            drive(0, 0, 0, 0, 0, 32'h604);
            #1;
            if (!busy) break;
            n++;
            if (n == 10) flush = 1'b1;
            tick();
        end
        chk("restart busy cycles", n, 10 + DEPTH);
        chk("hit after restart", {31'b0, pred_hit}, 32'd0);

        // ---- reset mid-sweep ----
        drive(1, 32'h17C, 1, 32'h900, 0, 32'h17C);
        tick();
        #1;
        chk("idx31 alloc hit", {31'b0, pred_hit}, 32'd1);
        drive(0, 0, 0, 0, 1, 32'h17C);
        tick();
        drive(0, 0, 0, 0, 0, 32'h17C);
        repeat (5) tick();
        #1;
        chk("mid sweep busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset hit", {31'b0, pred_hit}, 32'd0);
        chk("reset tgt", pred_target, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        chk("after reset hit", {31'b0, pred_hit}, 32'd0);
        chk("after reset busy", {31'b0, busy}, 32'd0);
        tick();

        // ---- random traffic against the model ----
        for (int c = 0; c < 1500; c++) begin
            rpc = XLEN'((($urandom_range(0, 3)) << 7) | (($urandom_range(0, 7)) << 2)
                        | $urandom_range(0, 3));
            drive(($urandom_range(0, 1) == 1), rpc, ($urandom_range(0, 2) != 0),
                  XLEN'($urandom), ($urandom_range(0, 99) == 0), 32'h0);
            pred_pc = XLEN'((($urandom_range(0, 3)) << 7) | (($urandom_range(0, 7)) << 2));
            #1;
            model_pred(pred_pc, mh, mt, mtg);
            chk($sformatf("rnd%0d hit", c),   {31'b0, pred_hit},   {31'b0, mh});
            chk($sformatf("rnd%0d taken", c), {31'b0, pred_taken}, {31'b0, mt});
            chk($sformatf("rnd%0d tgt", c),   pred_target,         mtg);
            chk($sformatf("rnd%0d busy", c),  {31'b0, busy},       {31'b0, (m_busy_left > 0)});
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
